text_buffer_ctrl: RTL and testbench

//  Write-side controller for the 64x16 character buffer that feeds the VGA text display.
//  - The display reads the buffer through its own port (sel/data). This block owns the buffer write port.
//  - Three write sources share that port: CPU MMIO stores, a cursor-based console stream, and clear/newline sweeps.

---
 rtl/text_buffer_ctrl.sv | 113 +++++++++++
 tb/tb_text_buffer_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/text_buffer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : text_buffer_ctrl
//  Description : Write-port arbiter for the VGA text buffer (CPU stores,
//                console stream, clear and newline blanking sweeps).
//  Revision    : 1.0 - initial release
// ============================================================================
module text_buffer_ctrl #(
    parameter int          COLS    = 64,
    parameter int          ROWS    = 16,
    parameter int          ADDR_W  = 10,
    parameter logic [7:0]  BLANK   = 8'h00,
    parameter logic [7:0]  NEWLINE = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    input  logic              con_valid,
    input  logic [7:0]        con_char,
    output logic              con_ready,
    input  logic              clr_req,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [ADDR_W-1:0] cursor,
    output logic              busy
);

    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CLEAR   = 2'd1;
    localparam logic [1:0] S_ROWFILL = 2'd2;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W-1:0] r_cursor;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;

    logic              w_con_ready;
    logic [ROW_W-1:0]  w_row_inc;
    logic [ADDR_W-1:0] w_next_row;
    logic              w_row_last;
    logic              w_clear_last;

    assign w_con_ready  = (r_state == S_IDLE) & ~cpu_we & ~clr_req & rst;
    // Row index wraps naturally in ROW_W bits, giving the modulo-ROWS step.
    assign w_row_inc    = r_cursor[ADDR_W-1:COL_W] + ROW_W'(1);
    assign w_next_row   = {w_row_inc, {COL_W{1'b0}}};
    assign w_row_last   = &r_count[COL_W-1:0];
    assign w_clear_last = &r_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_cursor  <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (cpu_we) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= cpu_addr;
                r_wr_data <= cpu_wdata;
            end
            if (clr_req) begin
                r_state <= S_CLEAR;
                r_count <= '0;
            end else if (r_state != S_IDLE) begin
                // A CPU store stalls the sweep; the counter holds so no cell is skipped.
                if (!cpu_we) begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_count;
                    r_wr_data <= BLANK;
                    r_count   <= r_count + ADDR_W'(1);
                    if (r_state == S_CLEAR && w_clear_last) begin
                        r_state  <= S_IDLE;
                        r_cursor <= '0;
                    end else if (r_state == S_ROWFILL && w_row_last) begin
                        r_state <= S_IDLE;
                    end
                end
            end else if (con_valid && w_con_ready) begin
                if (con_char == NEWLINE) begin
                    r_cursor <= w_next_row;
                    r_count  <= w_next_row;
                    r_state  <= S_ROWFILL;
                end else begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_cursor;
                    r_wr_data <= con_char;
                    r_cursor  <= r_cursor + ADDR_W'(1);
                end
            end
        end
    end

    assign con_ready = w_con_ready;
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign cursor    = r_cursor;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_text_buffer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_text_buffer_ctrl
//  Description : Self-checking bench for text_buffer_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_text_buffer_ctrl;

    logic       clk = 1'b0;
    logic       rst, cpu_we, con_valid, clr_req;
    logic [9:0] cpu_addr;
    logic [7:0] cpu_wdata, con_char;
    logic       con_ready, wr_en, busy;
    logic [9:0] wr_addr, cursor;
    logic [7:0] wr_data;

    int checks = 0;
    int errors = 0;

    // Reference model: remaining sweep writes instead of a state machine.
    int         m_cursor = 0;
    int         m_left   = 0;
    int         m_pos    = 0;
    bit         m_clear  = 0;
    logic       m_en     = 0;
    logic [9:0] m_addr   = 0;
    logic [7:0] m_data   = 0;

    always #5 clk = ~clk;

    text_buffer_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .con_valid (con_valid),
        .con_char  (con_char),
        .con_ready (con_ready),
        .clr_req   (clr_req),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cursor    (cursor),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic w, input logic [9:0] a, input logic [7:0] d,
                        input logic v, input logic [7:0] c, input logic k);
        logic exp_ready;
        rst = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
        con_valid = v; con_char = c; clr_req = k;
        #1;
        exp_ready = (m_left == 0) && !w && !k && r;
        check("con_ready", {31'd0, con_ready}, {31'd0, exp_ready});
        if (!r) begin
            m_cursor = 0; m_left = 0; m_pos = 0; m_en = 0; m_addr = 0; m_data = 0;
        end else begin
            m_en = 0;
            if (w) begin m_en = 1; m_addr = a; m_data = d; end
            if (k) begin
                m_left = 1024; m_pos = 0; m_clear = 1;
            end else if (m_left > 0) begin
                if (!w) begin
                    m_en = 1; m_addr = 10'(m_pos); m_data = 8'h00;
                    m_pos = (m_pos + 1) % 1024;
                    m_left--;
                    if (m_left == 0 && m_clear) m_cursor = 0;
                end
            end else if (v && exp_ready) begin
                if (c == 8'hFF) begin
                    m_cursor = ((m_cursor / 64 + 1) % 16) * 64;
                    m_left = 64; m_pos = m_cursor; m_clear = 0;
                end else begin
                    m_en = 1; m_addr = 10'(m_cursor); m_data = c;
                    m_cursor = (m_cursor + 1) % 1024;
                end
            end
        end
        @(posedge clk);
        #1;
        check("wr_en", {31'd0, wr_en}, {31'd0, m_en});
        check("wr_addr", {22'd0, wr_addr}, {22'd0, m_addr});
        check("wr_data", {24'd0, wr_data}, {24'd0, m_data});
        check("cursor", {22'd0, cursor}, m_cursor);
        check("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
    endtask

    task automatic idle();
        step(1, 0, 10'd0, 8'd0, 0, 8'd0, 0);
    endtask

    task automatic send(input logic [7:0] c);
        step(1, 0, 10'd0, 8'd0, 1, c, 0);
    endtask

    typedef struct {
        logic       r, w;
        logic [9:0] a;
        logic [7:0] d;
        logic       v;
        logic [7:0] c;
        logic       k;
        logic       x_ready, x_en;
        logic [9:0] x_addr;
        logic [7:0] x_data;
        logic [9:0] x_cur;
    } vec_t;

    vec_t vecs[7];
    bit   hit[1024];

    initial begin
        int n, cyc, ncpu, dup, first;
        vecs[0] = '{0, 0, 10'h000, 8'h00, 0, 8'h00, 0, 0, 0, 10'h000, 8'h00, 10'd0};
        vecs[1] = '{1, 0, 10'h000, 8'h00, 1, 8'h13, 0, 1, 1, 10'h000, 8'h13, 10'd1};
        vecs[2] = '{1, 0, 10'h000, 8'h00, 1, 8'h18, 0, 1, 1, 10'h001, 8'h18, 10'd2};
        vecs[3] = '{1, 1, 10'h005, 8'hAA, 1, 8'h22, 0, 0, 1, 10'h005, 8'hAA, 10'd2};
        vecs[4] = '{1, 0, 10'h000, 8'h00, 0, 8'h00, 0, 1, 0, 10'h005, 8'hAA, 10'd2};
        vecs[5] = '{1, 1, 10'h3FF, 8'h77, 0, 8'h00, 0, 0, 1, 10'h3FF, 8'h77, 10'd2};
        vecs[6] = '{1, 0, 10'h000, 8'h00, 1, 8'h41, 0, 1, 1, 10'h002, 8'h41, 10'd3};

        rst = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; con_valid = 0; con_char = 0; clr_req = 0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            step(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].v, vecs[i].c, vecs[i].k);
            check("tbl_en", {31'd0, wr_en}, {31'd0, vecs[i].x_en});
            if (vecs[i].x_en || i == 0) begin
                check("tbl_addr", {22'd0, wr_addr}, {22'd0, vecs[i].x_addr});
                check("tbl_data", {24'd0, wr_data}, {24'd0, vecs[i].x_data});
            end
            check("tbl_cursor", {22'd0, cursor}, {22'd0, vecs[i].x_cur});
        end

        // Newline from cursor 70 blanks row 2.
        for (int i = 0; i < 67; i++) send(8'($urandom_range(0, 254)));
        check("cursor70", {22'd0, cursor}, 70);
        send(8'hFF);
        check("nl_cursor", {22'd0, cursor}, 128);
        check("nl_busy", {31'd0, busy}, 1);
        check("nl_no_write", {31'd0, wr_en}, 0);
        n = 0; cyc = 0; first = -1;
        while (busy && cyc < 200) begin
            idle(); cyc++;
            if (wr_en && wr_data == 8'h00 && wr_addr >= 128 && wr_addr <= 191) begin
                if (first < 0) first = int'(wr_addr);
                n++;
            end
        end
        check("rowfill_writes", n, 64);
        check("rowfill_first", first, 128);
        check("rowfill_done", {31'd0, busy}, 0);
        idle();
        check("ready_after_rowfill", {31'd0, con_ready}, 1);

        // Clear aborts an in-progress row fill.
        send(8'hFF);
        for (int i = 0; i < 5; i++) idle();
        step(1, 0, 10'd0, 8'd0, 1, 8'h31, 1);
        foreach (hit[i]) hit[i] = 0;
        n = 0; cyc = 0; dup = 0;
        while (busy && cyc < 1200) begin
            idle(); cyc++;
            if (wr_en) begin
                if (hit[wr_addr]) dup++;
                hit[wr_addr] = 1; n++;
            end
        end
        check("clear_writes", n, 1024);
        check("clear_dups", dup, 0);
        check("clear_cursor", {22'd0, cursor}, 0);
        check("clear_done", {31'd0, busy}, 0);

        // CPU stores every 4th cycle stall the clear sweep.
        step(1, 0, 10'd0, 8'd0, 0, 8'd0, 1);
        foreach (hit[i]) hit[i] = 0;
        n = 0; cyc = 0; dup = 0; ncpu = 0;
        while (busy && cyc < 1600) begin
            if (cyc % 4 == 3) begin
                step(1, 1, 10'($urandom_range(0, 1023)), 8'h55, 0, 8'd0, 0);
                ncpu++;
                check("stall_cpu_data", {24'd0, wr_data}, 32'h55);
            end else begin
                idle();
                if (wr_en) begin
                    if (hit[wr_addr]) dup++;
                    hit[wr_addr] = 1; n++;
                end
            end
            cyc++;
        end
        check("stall_sweep_writes", n, 1024);
        check("stall_dups", dup, 0);
        check("stall_total_cycles", cyc, 1024 + ncpu);

        // Cursor wrap at 1023 and newline from the last row.
        for (int i = 0; i < 1023; i++) send(8'($urandom_range(0, 254)));
        check("cursor1023", {22'd0, cursor}, 1023);
        send(8'h1C);
        check("wrap_addr", {22'd0, wr_addr}, 1023);
        check("wrap_data", {24'd0, wr_data}, 32'h1C);
        check("wrap_cursor", {22'd0, cursor}, 0);
        for (int j = 0; j < 15; j++) begin
            send(8'hFF);
            cyc = 0;
            while (busy && cyc < 100) begin idle(); cyc++; end
        end
        check("cursor3C0", {22'd0, cursor}, 32'h3C0);
        send(8'hFF);
        check("last_nl_cursor", {22'd0, cursor}, 0);
        n = 0; cyc = 0; first = -1;
        while (busy && cyc < 100) begin
            idle(); cyc++;
            if (wr_en && wr_addr <= 63) begin
                if (first < 0) first = int'(wr_addr);
                n++;
            end
        end
        check("row0_fill_writes", n, 64);
        check("row0_fill_first", first, 0);

        // Reset in the middle of a clear.
        step(1, 0, 10'd0, 8'd0, 0, 8'd0, 1);
        for (int i = 0; i < 100; i++) idle();
        step(0, 0, 10'd0, 8'd0, 1, 8'h20, 0);
        check("rst_wr_en", {31'd0, wr_en}, 0);
        check("rst_cursor", {22'd0, cursor}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        idle();
        check("rst_ready", {31'd0, con_ready}, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            logic [7:0] ch;
            ch = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
            step($urandom_range(0, 1999) != 0, $urandom_range(0, 5) == 0,
                 10'($urandom_range(0, 1023)), 8'($urandom_range(0, 255)),
                 $urandom_range(0, 9) < 7, ch, $urandom_range(0, 999) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
